brch_ckpt_ctrl: RTL and testbench

- Branch checkpoint controller in the allocation stage.
- Tracks in-flight speculative branches in an in-order FIFO. Each entry holds the branch's ROB index and the free-list allocation position to restore.
- Arbitrates dispatch, commit and mispredict on that FIFO, and stalls dispatch when checkpoints run out.
- On mispredict, squashes the offending branch and all younger branches, and returns the recovery position to the free list.

---
 rtl/brch_ckpt_ctrl_pkg.sv | 23 ++
 rtl/brch_ckpt_ctrl_if.sv | 36 +++
 rtl/brch_ckpt_match.sv | 34 +++
 rtl/brch_ckpt_ctrl.sv | 128 ++++++++++++
 tb/tb_brch_ckpt_ctrl.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/brch_ckpt_ctrl_pkg.sv
// Shared types for the allocation-stage bookkeeping blocks (checkpoints, free list, ROB).
package brch_ckpt_ctrl_pkg;

  localparam int unsigned IDX_W = 6;  // ROB index width
  localparam int unsigned POS_W = 7;  // free-list allocation position width
  localparam int unsigned SLOTS = 4;  // instructions per dispatch group

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic [POS_W-1:0] pos;
  } ckpt_entry_t;

  // Number of branches flagged in a dispatch group.
  function automatic int unsigned popcnt_slots(input logic [SLOTS-1:0] v);
    int unsigned c;
    c = 0;
    for (int i = 0; i < SLOTS; i++) begin
      if (v[i]) c++;
    end
    return c;
  endfunction

endpackage

// File: rtl/brch_ckpt_ctrl_if.sv
// Dispatch / commit / mispredict bundle between the pipeline and the checkpoint controller.
interface brch_ckpt_ctrl_if
  import brch_ckpt_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) ();

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic                   dsp_vld;
  logic [SLOTS-1:0]       brch_in;
  logic [SLOTS*IDX_W-1:0] brch_idx_in;
  logic [SLOTS*POS_W-1:0] alloc_pos_in;
  logic                   cmt_brch;
  logic [IDX_W-1:0]       cmt_brch_indx;
  logic                   mis_pred;
  logic [IDX_W-1:0]       brch_mis_indx;
  logic                   stall_out;
  logic [CNT_W-1:0]       brnc_cnt_out;
  logic                   rcvr_vld_out;
  logic [POS_W-1:0]       rcvr_pos_out;
  logic                   err_out;

  modport master (
    output dsp_vld, brch_in, brch_idx_in, alloc_pos_in,
    output cmt_brch, cmt_brch_indx, mis_pred, brch_mis_indx,
    input  stall_out, brnc_cnt_out, rcvr_vld_out, rcvr_pos_out, err_out
  );

  modport slave (
    input  dsp_vld, brch_in, brch_idx_in, alloc_pos_in,
    input  cmt_brch, cmt_brch_indx, mis_pred, brch_mis_indx,
    output stall_out, brnc_cnt_out, rcvr_vld_out, rcvr_pos_out, err_out
  );

endinterface

// File: rtl/brch_ckpt_match.sv
// Combinational search of the live checkpoint window for a ROB index.
// Returns the oldest matching entry as an offset from head.
module brch_ckpt_match
  import brch_ckpt_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  ckpt_entry_t [DEPTH-1:0]   ent,
  input  logic [$clog2(DEPTH)-1:0]  head,
  input  logic [$clog2(DEPTH):0]    cnt,
  input  logic [IDX_W-1:0]          key,
  output logic                      hit,
  output logic [$clog2(DEPTH)-1:0]  off
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW-1:0] slot;

  // Walk from head so only valid entries (offset < cnt) can match, wrap handled by AW-bit add.
  always_comb begin
    hit  = 1'b0;
    off  = '0;
    slot = '0;
    for (int i = 0; i < DEPTH; i++) begin
      slot = head + AW'(i);
      if (!hit && (i < int'(cnt)) && (ent[slot].idx == key)) begin
        hit = 1'b1;
        off = AW'(i);
      end
    end
  end

endmodule

// File: rtl/brch_ckpt_ctrl.sv
// Branch checkpoint controller: in-order FIFO of {ROB index, free-list position} per
// in-flight branch, with dispatch stall, in-order commit and mispredict truncation.
module brch_ckpt_ctrl
  import brch_ckpt_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input logic             clk,
  input logic             rst,
  brch_ckpt_ctrl_if.slave bus
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned PTR_W = AW + 1;  // extra wrap bit
  localparam int unsigned CNT_W = AW + 1;

  ckpt_entry_t [DEPTH-1:0] ent_q;
  ckpt_entry_t [DEPTH-1:0] wr_data;
  logic [DEPTH-1:0]        wr_en;
  logic [AW-1:0]           wr_slot;

  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rvld_q, rvld_d;
  logic [POS_W-1:0] rpos_q, rpos_d;
  logic             err_q, err_d;

  int unsigned   n_brch;
  logic          stall, dsp_do, cmt_ok, mis_hit;
  logic [AW-1:0] mis_off, mis_slot, head_slot;

  assign head_slot = head_q[AW-1:0];

  brch_ckpt_match #(
    .DEPTH (DEPTH)
  ) u_match (
    .ent  (ent_q),
    .head (head_slot),
    .cnt  (cnt_q),
    .key  (bus.brch_mis_indx),
    .hit  (mis_hit),
    .off  (mis_off)
  );

  // Stall ignores a same-cycle commit: only already-free slots count.
  always_comb begin
    n_brch = popcnt_slots(bus.brch_in);
    stall  = bus.dsp_vld && (n_brch > (DEPTH - 32'(cnt_q)));
  end

  // Next-state arbitration of dispatch, commit and mispredict.
  always_comb begin
    head_d   = head_q;
    tail_d   = tail_q;
    cnt_d    = cnt_q;
    rvld_d   = 1'b0;
    rpos_d   = rpos_q;
    err_d    = err_q;
    wr_en    = '0;
    wr_data  = '0;
    wr_slot  = tail_q[AW-1:0];
    mis_slot = head_slot + mis_off;

    // A commit naming the entry being mispredicted is a protocol error and is dropped.
    cmt_ok = bus.cmt_brch && (cnt_q != '0) && (ent_q[head_slot].idx == bus.cmt_brch_indx) &&
             !(bus.mis_pred && mis_hit && (mis_off == '0));
    // Any dispatch alongside a mispredict is younger and therefore squashed.
    dsp_do = bus.dsp_vld && !stall && !bus.mis_pred;

    if (bus.cmt_brch && !cmt_ok) err_d = 1'b1;
    if (bus.mis_pred && !mis_hit) err_d = 1'b1;
    if (cmt_ok) head_d = head_q + PTR_W'(1);

    if (bus.mis_pred && mis_hit) begin
      tail_d = head_q + PTR_W'(mis_off);
      cnt_d  = CNT_W'(mis_off) - CNT_W'(cmt_ok);
      rvld_d = 1'b1;
      rpos_d = ent_q[mis_slot].pos;
    end else begin
      cnt_d = cnt_q - CNT_W'(cmt_ok);
      if (dsp_do) begin
        for (int k = 0; k < SLOTS; k++) begin
          if (bus.brch_in[k]) begin
            wr_en[wr_slot]       = 1'b1;
            wr_data[wr_slot].idx = bus.brch_idx_in[k*IDX_W +: IDX_W];
            wr_data[wr_slot].pos = bus.alloc_pos_in[k*POS_W +: POS_W];
            wr_slot              = wr_slot + AW'(1);
          end
        end
        tail_d = tail_q + PTR_W'(n_brch);
        cnt_d  = cnt_d + CNT_W'(n_brch);
      end
    end
  end

  // Control state; reset clears pointers, count and any pending recovery pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
      rvld_q <= 1'b0;
      rpos_q <= '0;
      err_q  <= 1'b0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
      rvld_q <= rvld_d;
      rpos_q <= rpos_d;
      err_q  <= err_d;
    end
  end

  // Entry storage; contents outside the live window are don't-care, so no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (wr_en[i]) ent_q[i] <= wr_data[i];
    end
  end

  assign bus.stall_out    = stall;
  assign bus.brnc_cnt_out = cnt_q;
  assign bus.rcvr_vld_out = rvld_q;
  assign bus.rcvr_pos_out = rpos_q;
  assign bus.err_out      = err_q;

endmodule

// File: tb/tb_brch_ckpt_ctrl.sv
// Self-checking bench for brch_ckpt_ctrl: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_brch_ckpt_ctrl;
  import brch_ckpt_ctrl_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  brch_ckpt_ctrl_if #(.DEPTH(DEPTH)) bus ();

  brch_ckpt_ctrl #(
    .DEPTH (DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: youngest at the back of the queue.
  ckpt_entry_t      m_q[$];
  logic             m_err  = 1'b0;
  logic             m_rvld = 1'b0;
  logic [POS_W-1:0] m_rpos = '0;

  function automatic int popc(input logic [3:0] v);
    return int'(v[0]) + int'(v[1]) + int'(v[2]) + int'(v[3]);
  endfunction

  function automatic logic m_stall();
    return bus.dsp_vld && (popc(bus.brch_in) > int'(DEPTH) - m_q.size());
  endfunction

  task automatic model_step();
    int          hit;
    logic        stl;
    logic        ok;
    ckpt_entry_t e;
    hit = -1;
    for (int i = 0; i < m_q.size(); i++) begin
      if (hit < 0 && m_q[i].idx == bus.brch_mis_indx) hit = i;
    end
    stl = m_stall();
    ok  = bus.cmt_brch && m_q.size() > 0 && m_q[0].idx == bus.cmt_brch_indx &&
          !(bus.mis_pred && hit == 0);
    m_rvld = 1'b0;
    if (bus.mis_pred) begin
      if (hit >= 0) begin
        m_rvld = 1'b1;
        m_rpos = m_q[hit].pos;
        while (m_q.size() > hit) void'(m_q.pop_back());
      end else begin
        m_err = 1'b1;
      end
    end
    if (bus.cmt_brch) begin
      if (ok) void'(m_q.pop_front());
      else m_err = 1'b1;
    end
    if (bus.dsp_vld && !stl && !bus.mis_pred) begin
      for (int k = 0; k < 4; k++) begin
        if (bus.brch_in[k]) begin
          e.idx = bus.brch_idx_in[k*IDX_W +: IDX_W];
          e.pos = bus.alloc_pos_in[k*POS_W +: POS_W];
          m_q.push_back(e);
        end
      end
    end
  endtask

  // Compare process: inputs change only just after posedge, so negedge sees settled values.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        m_q.delete();
        m_err  = 1'b0;
        m_rvld = 1'b0;
        m_rpos = '0;
        check("rst_stall", bus.stall_out, 0);
        check("rst_cnt", bus.brnc_cnt_out, 0);
        check("rst_rvld", bus.rcvr_vld_out, 0);
        check("rst_rpos", bus.rcvr_pos_out, 0);
        check("rst_err", bus.err_out, 0);
      end else begin
        check("mdl_stall", bus.stall_out, m_stall());
        check("mdl_cnt", bus.brnc_cnt_out, m_q.size());
        check("mdl_rvld", bus.rcvr_vld_out, m_rvld);
        if (m_rvld) check("mdl_rpos", bus.rcvr_pos_out, m_rpos);
        check("mdl_err", bus.err_out, m_err);
        model_step();
      end
    end
  end

  task automatic clr();
    bus.dsp_vld       = 1'b0;
    bus.brch_in       = '0;
    bus.brch_idx_in   = '0;
    bus.alloc_pos_in  = '0;
    bus.cmt_brch      = 1'b0;
    bus.cmt_brch_indx = '0;
    bus.mis_pred      = 1'b0;
    bus.brch_mis_indx = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    clr();
  endtask

  task automatic disp(input logic [3:0] b, input int i0, input int i1, input int i2,
                      input int i3, input int p0, input int p1, input int p2, input int p3);
    bus.dsp_vld      = 1'b1;
    bus.brch_in      = b;
    bus.brch_idx_in  = {IDX_W'(i3), IDX_W'(i2), IDX_W'(i1), IDX_W'(i0)};
    bus.alloc_pos_in = {POS_W'(p3), POS_W'(p2), POS_W'(p1), POS_W'(p0)};
  endtask

  task automatic cmt(input int i);
    bus.cmt_brch      = 1'b1;
    bus.cmt_brch_indx = IDX_W'(i);
  endtask

  task automatic mis(input int i);
    bus.mis_pred      = 1'b1;
    bus.brch_mis_indx = IDX_W'(i);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    clr();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    check("init_cnt", bus.brnc_cnt_out, 0);
    check("init_err", bus.err_out, 0);

    // Two branches from slots 0 and 2.
    disp(4'b0101, 3, 0, 5, 0, 'h10, 0, 'h14, 0);
    #1 check("d1_stall", bus.stall_out, 0);
    tick();
    check("d1_cnt", bus.brnc_cnt_out, 2);
    disp(4'b0001, 7, 0, 0, 0, 'h20, 0, 0, 0);
    tick();
    check("d2_cnt", bus.brnc_cnt_out, 3);

    // Two more than one free slot: stall, also with a head commit the same cycle.
    disp(4'b0011, 8, 9, 0, 0, 'h21, 'h22, 0, 0);
    #1 check("st_stall", bus.stall_out, 1);
    tick();
    check("st_cnt", bus.brnc_cnt_out, 3);
    disp(4'b0011, 8, 9, 0, 0, 'h21, 'h22, 0, 0);
    cmt(3);
    #1 check("stc_stall", bus.stall_out, 1);
    tick();
    check("stc_cnt", bus.brnc_cnt_out, 2);

    // Mispredict on the head entry 5 empties the FIFO.
    mis(5);
    tick();
    check("m0_rvld", bus.rcvr_vld_out, 1);
    check("m0_rpos", bus.rcvr_pos_out, 'h14);
    check("m0_cnt", bus.brnc_cnt_out, 0);
    tick();
    check("m0_pulse", bus.rcvr_vld_out, 0);

    // Fill all four, then mispredict idx 2 with a dropped same-cycle dispatch.
    disp(4'b1111, 1, 2, 3, 4, 1, 2, 3, 4);
    #1 check("full_stall", bus.stall_out, 0);
    tick();
    check("full_cnt", bus.brnc_cnt_out, 4);
    mis(2);
    disp(4'b0001, 9, 0, 0, 0, 'h09, 0, 0, 0);
    tick();
    check("m1_rvld", bus.rcvr_vld_out, 1);
    check("m1_rpos", bus.rcvr_pos_out, 'h02);
    check("m1_cnt", bus.brnc_cnt_out, 1);

    // Wrap: refill, retire three, add three, truncate in the middle.
    disp(4'b0111, 2, 3, 4, 0, 2, 3, 4, 0);
    tick();
    cmt(1); tick();
    cmt(2); tick();
    cmt(3); tick();
    check("w_cnt1", bus.brnc_cnt_out, 1);
    disp(4'b0111, 10, 11, 12, 0, 'h0A, 'h0B, 'h0C, 0);
    tick();
    check("w_cnt4", bus.brnc_cnt_out, 4);
    mis(11);
    tick();
    check("w_rpos", bus.rcvr_pos_out, 'h0B);
    check("w_cnt", bus.brnc_cnt_out, 2);
    cmt(4); tick();
    cmt(10); tick();
    disp(4'b0111, 20, 21, 22, 0, 'h30, 'h31, 'h32, 0);
    tick();
    mis(22);
    tick();
    check("w2_rvld", bus.rcvr_vld_out, 1);
    check("w2_rpos", bus.rcvr_pos_out, 'h32);
    check("w2_cnt", bus.brnc_cnt_out, 2);

    // Commit head and mispredict a younger entry in the same cycle.
    disp(4'b0011, 23, 24, 0, 0, 'h33, 'h34, 0, 0);
    tick();
    cmt(20);
    mis(23);
    tick();
    check("cm_cnt", bus.brnc_cnt_out, 1);
    check("cm_rpos", bus.rcvr_pos_out, 'h33);

    // Commit plus dispatch.
    cmt(21);
    disp(4'b1000, 0, 0, 0, 25, 0, 0, 0, 'h35);
    tick();
    check("cd_cnt", bus.brnc_cnt_out, 1);
    check("cd_err", bus.err_out, 0);

    // Protocol errors.
    cmt(7);
    tick();
    check("e1_err", bus.err_out, 1);
    check("e1_cnt", bus.brnc_cnt_out, 1);
    mis(33);
    tick();
    check("e2_rvld", bus.rcvr_vld_out, 0);
    check("e2_cnt", bus.brnc_cnt_out, 1);
    tick();
    check("e_sticky", bus.err_out, 1);
    cmt(25);
    mis(25);
    tick();
    check("se_rvld", bus.rcvr_vld_out, 1);
    check("se_rpos", bus.rcvr_pos_out, 'h35);
    check("se_cnt", bus.brnc_cnt_out, 0);

    // Reset mid-pulse clears everything immediately.
    disp(4'b0011, 40, 41, 0, 0, 'h40, 'h41, 0, 0);
    tick();
    mis(41);
    tick();
    check("pr_rvld", bus.rcvr_vld_out, 1);
    #2 rst = 1'b1;
    #1;
    check("ar_rvld", bus.rcvr_vld_out, 0);
    check("ar_rpos", bus.rcvr_pos_out, 0);
    check("ar_cnt", bus.brnc_cnt_out, 0);
    check("ar_err", bus.err_out, 0);
    @(posedge clk);
    #3 rst = 1'b0;
    disp(4'b0001, 50, 0, 0, 0, 'h50, 0, 0, 0);
    tick();
    check("post_cnt", bus.brnc_cnt_out, 1);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
